// File: rtl/rob_pkg.sv
// Shared definitions for the parametrised reorder buffer: default sizes,
// entry field layout and the tag-width helper.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_XLEN  = 32;
  localparam int ROB_REG_W = 5;

  // Entry layout when packed as one word: {val, pc, rd, done, valid}
  localparam int ENT_VALID   = 0;
  localparam int ENT_DONE    = 1;
  localparam int ENT_RD      = 2;
  localparam int ENT_PC      = ENT_RD + ROB_REG_W;
  localparam int ENT_VAL     = ENT_PC + ROB_XLEN;
  localparam int ROB_ENTRY_W = 2 + ROB_REG_W + 2*ROB_XLEN;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Folds the writeback ports into per-entry write enables and data.
// Later ports override earlier ones, so the highest port index wins.
module rob_wb_merge #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = 4,
  parameter int XLEN     = 32,
  parameter int WB_PORTS = 2
) (
  input  logic [WB_PORTS-1:0]            wb_valid,
  input  logic [WB_PORTS-1:0][TAG_W-1:0] wb_tag,
  input  logic [WB_PORTS-1:0][XLEN-1:0]  wb_val,
  input  logic [DEPTH-1:0]               ent_valid,
  input  logic [DEPTH-1:0]               ent_done,
  output logic [DEPTH-1:0]               we,
  output logic [DEPTH-1:0][XLEN-1:0]     wdata
);

  always_comb begin
    we    = '0;
    wdata = '0;
    // Eligibility is judged on registered state, so stale or repeated tags drop out
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && ent_valid[wb_tag[p]] && !ent_done[wb_tag[p]]) begin
        we[wb_tag[p]]    = 1'b1;
        wdata[wb_tag[p]] = wb_val[p];
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, tag-indexed multi-port
// writeback, in-order commit handshake, forwarding queries and flush.
module rob_param import rob_pkg::*; #(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int TAG_W    = tag_w(DEPTH),
  parameter int XLEN     = ROB_XLEN,
  parameter int REG_W    = ROB_REG_W,
  parameter int WB_PORTS = 2,
  parameter int RD_PORTS = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic                           push_valid,
  output logic                           push_ready,
  input  logic [REG_W-1:0]               push_rd,
  input  logic [XLEN-1:0]                push_pc,
  output logic [TAG_W-1:0]               alloc_tag,
  input  logic [WB_PORTS-1:0]            wb_valid,
  input  logic [WB_PORTS-1:0][TAG_W-1:0] wb_tag,
  input  logic [WB_PORTS-1:0][XLEN-1:0]  wb_val,
  input  logic [RD_PORTS-1:0][TAG_W-1:0] qry_tag,
  output logic [RD_PORTS-1:0]            qry_done,
  output logic [RD_PORTS-1:0][XLEN-1:0]  qry_val,
  output logic                           commit_valid,
  input  logic                           commit_ready,
  output logic [TAG_W-1:0]               commit_tag,
  output logic [REG_W-1:0]               commit_rd,
  output logic [XLEN-1:0]                commit_val,
  output logic [XLEN-1:0]                commit_pc,
  output logic [TAG_W:0]                 count,
  output logic                           empty
);

  logic [DEPTH-1:0]            ent_valid, ent_done;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd;
  logic [DEPTH-1:0][XLEN-1:0]  ent_pc, ent_val;
  logic [TAG_W-1:0]            front, rear;
  logic [TAG_W:0]              cnt_q;
  logic [DEPTH-1:0]            wb_we;
  logic [DEPTH-1:0][XLEN-1:0]  wb_wdata;
  logic                        push_fire, commit_fire;

  rob_wb_merge #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .WB_PORTS(WB_PORTS)
  ) u_wb_merge (
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .wb_val   (wb_val),
    .ent_valid(ent_valid),
    .ent_done (ent_done),
    .we       (wb_we),
    .wdata    (wb_wdata)
  );

  // No commit-to-push bypass: a full ROB refuses pushes even while draining
  assign push_ready   = cnt_q < (TAG_W+1)'(DEPTH);
  assign empty        = cnt_q == '0;
  assign count        = cnt_q;
  assign alloc_tag    = rear;
  assign push_fire    = push_valid && push_ready;
  assign commit_valid = rdy_in && ent_valid[front] && ent_done[front];
  assign commit_fire  = commit_valid && commit_ready;
  assign commit_tag   = front;
  assign commit_rd    = ent_rd[front];
  assign commit_pc    = ent_pc[front];
  assign commit_val   = ent_val[front];

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_qry
    assign qry_done[r] = ent_valid[qry_tag[r]] && ent_done[qry_tag[r]];
    assign qry_val[r]  = qry_done[r] ? ent_val[qry_tag[r]] : '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ent_valid <= '0;
      ent_done  <= '0;
      ent_rd    <= '0;
      ent_pc    <= '0;
      ent_val   <= '0;
      front     <= '0;
      rear      <= '0;
      cnt_q     <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        ent_valid <= '0;
        ent_done  <= '0;
        front     <= '0;
        rear      <= '0;
        cnt_q     <= '0;
      end else begin
        for (int d = 0; d < DEPTH; d++) begin
          if (wb_we[d]) begin
            ent_done[d] <= 1'b1;
            ent_val[d]  <= wb_wdata[d];
          end
        end
        // Head is always done and rear never valid here, so these never collide with writeback
        if (commit_fire) begin
          ent_valid[front] <= 1'b0;
          ent_done[front]  <= 1'b0;
          front            <= front + 1'b1;
        end
        if (push_fire) begin
          ent_valid[rear] <= 1'b1;
          ent_done[rear]  <= 1'b0;
          ent_rd[rear]    <= push_rd;
          ent_pc[rear]    <= push_pc;
          ent_val[rear]   <= '0;
          rear            <= rear + 1'b1;
        end
        case ({push_fire, commit_fire})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed and randomized checks of rob_param against a program-order queue model.
module tb_rob_param;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in, flush_in, push_valid, push_ready, commit_valid, commit_ready, empty;
  logic [4:0]       push_rd, commit_rd, count;
  logic [31:0]      push_pc, commit_val, commit_pc;
  logic [3:0]       alloc_tag, commit_tag;
  logic [1:0]       wb_valid, qry_done;
  logic [1:0][3:0]  wb_tag, qry_tag;
  logic [1:0][31:0] wb_val, qry_val;

  int checks = 0;
  int errors = 0;

  // Model: live tags in program order, plus per-tag payload
  int          q[$];
  int          rear = 0;
  bit          done[16];
  logic [31:0] mval[16], mpc[16];
  logic [4:0]  mrd[16];

  always #5 clk_in = ~clk_in;

  rob_param dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .push_valid(push_valid), .push_ready(push_ready), .push_rd(push_rd),
    .push_pc(push_pc), .alloc_tag(alloc_tag), .wb_valid(wb_valid),
    .wb_tag(wb_tag), .wb_val(wb_val), .qry_tag(qry_tag), .qry_done(qry_done),
    .qry_val(qry_val), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_tag(commit_tag), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_pc(commit_pc), .count(count), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic bit inq(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_cv();
    return rdy_in && q.size() > 0 && done[q[0]];
  endfunction

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; push_valid = 1'b0; commit_ready = 1'b0;
    push_rd = '0; push_pc = '0; wb_valid = '0; wb_tag = '0; wb_val = '0;
  endtask

  task automatic check_outputs();
    bit cv, d;
    int t;
    cv = exp_cv();
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("push_ready", 64'(push_ready), 64'(q.size() < 16));
    chk("alloc_tag", 64'(alloc_tag), 64'(rear));
    chk("commit_valid", 64'(commit_valid), 64'(cv));
    if (cv) begin
      chk("commit_tag", 64'(commit_tag), 64'(q[0]));
      chk("commit_rd", 64'(commit_rd), 64'(mrd[q[0]]));
      chk("commit_pc", 64'(commit_pc), 64'(mpc[q[0]]));
      chk("commit_val", 64'(commit_val), 64'(mval[q[0]]));
    end
    for (int r = 0; r < 2; r++) begin
      t = int'(qry_tag[r]);
      d = inq(t) && done[t];
      chk("qry_done", 64'(qry_done[r]), 64'(d));
      chk("qry_val", 64'(qry_val[r]), d ? 64'(mval[t]) : 64'(0));
    end
  endtask

  // One clock: check combinational outputs, then advance the model on the edge
  task automatic tick();
    bit cv, pf, cf;
    bit [1:0] ok;
    int t;
    #1;
    check_outputs();
    cv = exp_cv();
    @(posedge clk_in);
    if (rdy_in) begin
      if (flush_in) begin
        q.delete();
        rear = 0;
        foreach (done[i]) done[i] = 1'b0;
      end else begin
        pf = push_valid && q.size() < 16;
        cf = cv && commit_ready;
        for (int p = 0; p < 2; p++)
          ok[p] = wb_valid[p] && inq(int'(wb_tag[p])) && !done[wb_tag[p]];
        for (int p = 0; p < 2; p++)
          if (ok[p]) begin
            t = int'(wb_tag[p]);
            done[t] = 1'b1;
            mval[t] = wb_val[p];
          end
        if (cf) begin
          done[q[0]] = 1'b0;
          void'(q.pop_front());
        end
        if (pf) begin
          q.push_back(rear);
          done[rear] = 1'b0;
          mrd[rear]  = push_rd;
          mpc[rear]  = push_pc;
          rear = (rear + 1) % 16;
        end
      end
    end
    #1;
  endtask

  // Async reset asserted between edges and checked before any clock edge
  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_push_ready", 64'(push_ready), 64'(1));
    chk("rst_commit_valid", 64'(commit_valid), 64'(0));
    chk("rst_alloc_tag", 64'(alloc_tag), 64'(0));
    chk("rst_qry_done", 64'(qry_done), 64'(0));
    chk("rst_qry_val", 64'(qry_val), 64'(0));
    chk("rst_commit_data", {commit_pc, commit_val}, 64'(0));
    chk("rst_commit_rd_tag", 64'({commit_rd, commit_tag}), 64'(0));
    q.delete();
    rear = 0;
    foreach (done[i]) done[i] = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_rd = 5'($urandom);
      push_pc = 32'h1000 + 32'(4 * i);
      tick();
    end
    push_valid = 1'b0;
  endtask

  task automatic wb1(input int p, input logic [3:0] t, input logic [31:0] v);
    wb_valid = '0;
    wb_valid[p] = 1'b1;
    wb_tag[p] = t;
    wb_val[p] = v;
    tick();
    wb_valid = '0;
  endtask

  initial begin
    idle();
    qry_tag = '0;
    #1;
    do_reset();

    // Mid-run reset with three live entries
    push(3);
    qry_tag[0] = 4'd1;
    wb1(0, 4'd1, 32'h77);
    #2;
    do_reset();

    // Fill, refuse the 17th push despite a same-cycle commit, then wrap
    push(16);
    chk("full_count", 64'(count), 64'(16));
    chk("full_ready", 64'(push_ready), 64'(0));
    wb1(0, 4'd0, 32'hA5);
    push_valid = 1'b1;
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    chk("refused_count", 64'(count), 64'(15));
    chk("wrap_tag", 64'(alloc_tag), 64'(0));
    push(1);
    chk("wrap_count", 64'(count), 64'(16));

    // Flush with five live entries plus same-cycle push and writeback
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    push(5);
    flush_in = 1'b1;
    push_valid = 1'b1;
    wb_valid = 2'b01; wb_tag[0] = 4'd1; wb_val[0] = 32'h55;
    tick();
    idle();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_rear", 64'(alloc_tag), 64'(0));
    qry_tag[0] = 4'd4;
    wb1(0, 4'd4, 32'h44);
    chk("stale_qry_done", 64'(qry_done[0]), 64'(0));

    // Out-of-order completion, in-order commit
    push(3);
    commit_ready = 1'b1;
    wb1(0, 4'd2, 32'h22);
    chk("head_not_done", 64'(commit_valid), 64'(0));
    wb1(1, 4'd0, 32'hA5);
    chk("head0_val", 64'(commit_val), 64'hA5);
    tick();
    chk("head1_wait", 64'(commit_valid), 64'(0));
    wb1(0, 4'd1, 32'h11);
    tick();
    chk("head2_tag", 64'(commit_tag), 64'(2));
    tick();
    commit_ready = 1'b0;
    chk("drained", 64'(empty), 64'(1));

    // Same tag on both ports: higher port wins; repeat writeback ignored
    push(1);
    qry_tag[0] = 4'd3;
    wb_valid = 2'b11; wb_tag = {4'd3, 4'd3}; wb_val = {32'h22, 32'h11};
    tick();
    wb_valid = '0;
    chk("same_tag_val", 64'(qry_val[0]), 64'h22);
    wb1(0, 4'd3, 32'h33);
    chk("redone_val", 64'(qry_val[0]), 64'h22);

    // rdy_in low freezes a committable head
    commit_ready = 1'b1;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen_cv", 64'(commit_valid), 64'(0));
      chk("frozen_count", 64'(count), 64'(1));
    end
    rdy_in = 1'b1;
    tick();
    chk("resumed_empty", 64'(empty), 64'(1));

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rdy_in = $urandom_range(0, 9) != 0;
      flush_in = $urandom_range(0, 59) == 0;
      push_valid = $urandom_range(0, 99) < 60;
      push_rd = 5'($urandom);
      push_pc = $urandom;
      commit_ready = $urandom_range(0, 3) != 0;
      for (int p = 0; p < 2; p++) begin
        wb_valid[p] = 1'($urandom_range(0, 1));
        wb_tag[p] = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                    4'(q[$urandom_range(0, q.size() - 1)]) : 4'($urandom_range(0, 15));
        wb_val[p] = $urandom;
        qry_tag[p] = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer, successor to the fixed 16-entry single-writeback ROB.
- Allocates entries in program order from dispatch and takes results from WB_PORTS execution/LSB writeback ports, indexed directly by tag.
- Retires completed head entries in order through a valid/ready commit handshake.
- Adds operand-forwarding query ports, full/empty/occupancy status, and flush. Sits between dispatch (foq/rs/lsb) and the register file / branch predictor.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2.
- TAG_W, 4, tag width; equals log2(DEPTH).
- XLEN, 32, data and address width.
- REG_W, 5, architectural destination register index width.
- WB_PORTS, 2, number of writeback ports.
- RD_PORTS, 2, number of forwarding query ports.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- flush_in  in  1  predict-fail clear.
- push_valid  in  1  dispatch request.
- push_ready  out  1  entry available (!full).
- push_rd  in  REG_W  destination register.
- push_pc  in  XLEN  source instruction address.
- alloc_tag  out  TAG_W  tag assigned on push (= rear index).
- wb_valid  in  WB_PORTS  per-port result strobe.
- wb_tag  in  WB_PORTS*TAG_W  packed tags; port p at [p*TAG_W +: TAG_W].
- wb_val  in  WB_PORTS*XLEN  packed results.
- qry_tag  in  RD_PORTS*TAG_W  forwarding lookup tags.
- qry_done  out  RD_PORTS  entry valid and done.
- qry_val  out  RD_PORTS*XLEN  entry value.
- commit_valid  out  1  head valid and done and rdy_in.
- commit_ready  in  1  consumer accepts head.
- commit_tag  out  TAG_W  head tag.
- commit_rd  out  REG_W  head destination register.
- commit_val  out  XLEN  head value.
- commit_pc  out  XLEN  head address.
- count  out  TAG_W+1  occupancy, 0..DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Entry fields: valid, done, rd, pc, val. Pointers front/rear are TAG_W bits and wrap naturally at DEPTH-1 -> 0. Occupancy is held in a TAG_W+1 counter.
- Reset (async, rst_in low):
  - All entries are invalid; front = rear = count = 0.
  - Outputs: push_ready=1, empty=1, commit_valid=0, alloc_tag=0, qry_done=0, all data outputs 0.
- rdy_in low: no state changes. commit_valid is forced to 0. Combinational outputs still reflect the current state.
- Priority within an enabled cycle: flush > {push, writeback, commit}. Flush invalidates every entry and zeroes front/rear/count; any same-cycle push, writeback or commit is dropped.
- Push: fires when push_valid && push_ready.
  - Writes {valid=1, done=0, rd, pc, val=0} at rear; rear increments.
  - alloc_tag shows rear combinationally in the same cycle.
  - push_ready depends only on registered count (count < DEPTH). There is no same-cycle bypass, so a full ROB that commits this cycle still refuses the push.
- Writeback:
  - Port p sets done=1 and val at index wb_tag[p], only if that entry is valid and not done. Otherwise it is ignored, including stale tags after a flush.
  - Two ports with the same tag in one cycle: the higher port index wins; the entry is written once.
  - Results are visible to commit and query the following cycle; there is no same-cycle writeback-to-commit bypass.
- Commit: fires when commit_valid && commit_ready. It invalidates the head and front increments. Head outputs are combinational from the entry at front.
- count update: count += push_fire - commit_fire. A simultaneous push and commit leaves count unchanged. A push into an empty ROB cannot commit in the same cycle.
- Query: combinational read of entry qry_tag[r]. qry_done = valid && done. qry_val = val when qry_done, else 0.
- Invariants:
  - count never exceeds DEPTH.
  - front == rear implies count is 0 or DEPTH.
  - Wrap-around is exercised once DEPTH pushes have occurred.

Decomposition:
- Shared package rob_pkg holds:
  - default DEPTH/XLEN/REG_W;
  - entry field offsets and ROB_ENTRY_W = 2 + REG_W + 2*XLEN;
  - the tag width helper.
- One natural sub-module, rob_wb_merge: resolves the WB_PORTS writebacks into per-entry write-enable and data, with highest-port-wins.

Test Plan:
- Reset mid-run (3 entries live, rst_in low for 1 cycle) -> count=0, empty=1, push_ready=1, commit_valid=0 immediately, asynchronously.
- 16 pushes with DEPTH=16 -> alloc_tag 0..15, count=16, push_ready=0. A 17th push with a same-cycle commit is refused; the next push gets alloc_tag 0 (wrap).
- Push tags 0,1,2; write back tag 2 then tag 0 (val 0xA5) -> commit_valid rises only after tag 0 is done. Commit order is 0, then (after tag 1 is done) 1, then 2.
- Same-cycle wb port0 and port1 both tag 3, vals 0x11/0x22 -> entry 3 val=0x22. A second writeback to done tag 3 with 0x33 is ignored.
- Flush with 5 live entries plus a same-cycle push and writeback -> count=0, rear=0. A next-cycle writeback to old tag 4 is ignored; qry_done for tag 4 is 0.
- rdy_in low for 3 cycles while a done head has commit_ready=1 -> commit_valid=0 and count constant; it resumes committing when rdy_in=1.
